// File: rtl/wb_regfile_param_pkg.sv
// Shared definitions for the write-back stage and its register file:
// stat codes, instruction codes, special register ids and the W-stage
// control bundle.
package wb_regfile_param_pkg;

  // Pipeline status codes carried with every instruction.
  typedef enum logic [3:0] {
    STAT_AOK = 4'h1,
    STAT_HLT = 4'h2,
    STAT_ADR = 4'h3,
    STAT_INS = 4'h4
  } stat_e;

  // Instruction codes.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ids at the default 4-bit id width. The top derives its own
  // "no register" value from ADDR_W so wider id spaces keep working.
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  // Width-independent part of the W-stage bundle; the data and id fields
  // depend on module parameters and are added around it in the top.
  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
  } w_ctrl_t;

endpackage

// File: rtl/wb_regfile_param_regfile_2w3r.sv
// NREGS x DATA_W register file with two write ports (E and M) and three
// combinational read ports. When both write ports hit the same id on one
// edge the M port wins. Out-of-range and "no register" ids never write and
// read back as zero.
module regfile_2w3r
  import wb_regfile_param_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NREGS      = 15,
  parameter int ADDR_W     = 4,
  parameter int RESET_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_e,
  input  logic [ADDR_W-1:0] addr_e,
  input  logic [DATA_W-1:0] data_e,
  input  logic              we_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] data_m,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] raddr_d,
  output logic [DATA_W-1:0] rdata_d
);

  localparam logic [ADDR_W:0] NREGS_ID = (ADDR_W+1)'(NREGS);

  logic [DATA_W-1:0] mem [NREGS];

  // True for ids that name a real architectural register.
  function automatic logic in_range(input logic [ADDR_W-1:0] id);
    return (id != '1) && ({1'b0, id} < NREGS_ID);
  endfunction

  // Storage update: reset image, then E write, then M write.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every reader in this edge sees the
    // pre-edge value; blocking assignments here would create order races.
    if (rst) begin
      // NOTE: the storage array is reset on purpose -- software relies on a
      // defined register image, so this is flops, not an inferred RAM.
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= (RESET_INIT != 0) ? DATA_W'(i) : '0;
      end
    end else begin
      if (we_e && in_range(addr_e)) mem[addr_e] <= data_e;
      // NOTE: for two non-blocking writes to one element the later statement
      // takes effect, which gives the M port priority over the E port.
      if (we_m && in_range(addr_m)) mem[addr_m] <= data_m;
    end
  end

  assign rdata_a = in_range(raddr_a) ? mem[raddr_a] : '0;
  assign rdata_b = in_range(raddr_b) ? mem[raddr_b] : '0;
  assign rdata_d = in_range(raddr_d) ? mem[raddr_d] : '0;

endmodule

// File: rtl/wb_regfile_param.sv
// Write-back stage: W pipeline register with stall/bubble control, commit
// of W into the register file, sticky halt on a non-AOK stat, a retired
// instruction counter, two bypassed decode read ports and a debug port.
module wb_regfile_param
  import wb_regfile_param_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NREGS      = 15,
  parameter int ADDR_W     = 4,
  parameter int RESET_INIT = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [ADDR_W-1:0] m_dstE,
  input  logic [ADDR_W-1:0] m_dstM,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [ADDR_W-1:0] RNONE_ID = '1;
  localparam logic [ADDR_W:0]   NREGS_ID = (ADDR_W+1)'(NREGS);

  typedef struct packed {
    w_ctrl_t           ctrl;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_m;
    logic [ADDR_W-1:0] dst_e;
    logic [ADDR_W-1:0] dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    ctrl:  '{stat: STAT_AOK, icode: I_NOP},
    val_e: '0,
    val_m: '0,
    dst_e: RNONE_ID,
    dst_m: RNONE_ID
  };

  w_reg_t            w_q;
  w_reg_t            w_d;
  logic              commit_ok;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  function automatic logic id_ok(input logic [ADDR_W-1:0] id);
    return (id != RNONE_ID) && ({1'b0, id} < NREGS_ID);
  endfunction

  // W commits only while running and carrying a clean stat.
  assign commit_ok = (w_q.ctrl.stat == STAT_AOK) && !halted;

  // Next W contents: stall beats bubble beats a fresh load; frozen once halted.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch
    // is inferred whatever branches are added later.
    w_d = w_q;
    if (!halted) begin
      if (w_stall) begin
        w_d = w_q;
      end else if (w_bubble) begin
        w_d = W_BUBBLE;
      end else begin
        w_d.ctrl.stat  = m_stat;
        w_d.ctrl.icode = m_icode;
        w_d.val_e      = m_valE;
        w_d.val_m      = m_valM;
        w_d.dst_e      = m_dstE;
        w_d.dst_m      = m_dstM;
      end
    end
  end

  // W register, sticky halt and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q        <= W_BUBBLE;
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      w_q <= w_d;
      if (w_q.ctrl.stat != STAT_AOK) halted <= 1'b1;
      if (commit_ok && (w_q.ctrl.icode != I_NOP)) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  regfile_2w3r #(
    .DATA_W     (DATA_W),
    .NREGS      (NREGS),
    .ADDR_W     (ADDR_W),
    .RESET_INIT (RESET_INIT)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we_e    (commit_ok),
    .addr_e  (w_q.dst_e),
    .data_e  (w_q.val_e),
    .we_m    (commit_ok),
    .addr_m  (w_q.dst_m),
    .data_m  (w_q.val_m),
    .raddr_a (srcA),
    .rdata_a (rd_a),
    .raddr_b (srcB),
    .rdata_b (rd_b),
    .raddr_d (dbg_addr),
    .rdata_d (dbg_data)
  );

  // Decode read ports: forward the write W is about to commit, M before E.
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (commit_ok && id_ok(srcA)) begin
      if (w_q.dst_m == srcA)      valA = w_q.val_m;
      else if (w_q.dst_e == srcA) valA = w_q.val_e;
    end
    if (commit_ok && id_ok(srcB)) begin
      if (w_q.dst_m == srcB)      valB = w_q.val_m;
      else if (w_q.dst_e == srcB) valB = w_q.val_e;
    end
  end

  assign W_stat  = w_q.ctrl.stat;
  assign W_icode = w_q.ctrl.icode;

endmodule

// File: tb/tb_wb_regfile_param.sv
// Bench for wb_regfile_param: an instruction-level model of the write-back
// stage checked against the DUT on every negative edge, directed scenarios
// with literal expectations, then a randomized run.
module tb_wb_regfile_param;
  import wb_regfile_param_pkg::*;

  localparam int DATA_W = 64;
  localparam int NREGS  = 15;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst;
  logic              w_stall;
  logic              w_bubble;
  logic [3:0]        m_stat;
  logic [3:0]        m_icode;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valM;
  logic [ADDR_W-1:0] m_dstE;
  logic [ADDR_W-1:0] m_dstM;
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [3:0]        W_stat;
  logic [3:0]        W_icode;
  logic              halted;
  logic [CNT_W-1:0]  retire_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  wb_regfile_param #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W), .RESET_INIT(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .w_stall(w_stall), .w_bubble(w_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .W_stat(W_stat), .W_icode(W_icode), .halted(halted), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The instruction currently sitting in W, the architectural registers,
  // the halt flag and the number of instructions retired so far.
  logic [63:0] arch [NREGS];
  int          wi_stat, wi_icode, wi_dste, wi_dstm;
  logic [63:0] wi_vale, wi_valm;
  bit          m_halted;
  longint      m_retired;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) arch[i] = 64'(i);
    wi_stat = 1; wi_icode = 1; wi_dste = 15; wi_dstm = 15;
    wi_vale = 0; wi_valm = 0;
    m_halted = 0; m_retired = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      bit was_halted;
      bit clean;
      was_halted = m_halted;
      clean = (wi_stat == 1);
      // The instruction in W takes effect only if it is clean and we run.
      if (clean && !was_halted) begin
        if (wi_dste < NREGS) arch[wi_dste] = wi_vale;
        if (wi_dstm < NREGS) arch[wi_dstm] = wi_valm;
        if (wi_icode != 1) m_retired++;
      end
      if (!clean) m_halted = 1;
      if (!was_halted && !w_stall) begin
        if (w_bubble) begin
          wi_stat = 1; wi_icode = 1; wi_dste = 15; wi_dstm = 15;
          wi_vale = 0; wi_valm = 0;
        end else begin
          wi_stat = int'(m_stat); wi_icode = int'(m_icode);
          wi_dste = int'(m_dstE); wi_dstm = int'(m_dstM);
          wi_vale = m_valE; wi_valm = m_valM;
        end
      end
    end
  end

  // Value a decode read of register id must return right now.
  function automatic logic [63:0] want_read(input int id);
    if (id >= NREGS) return 64'd0;
    if (wi_stat == 1 && !m_halted) begin
      if (wi_dstm == id) return wi_valm;
      if (wi_dste == id) return wi_vale;
    end
    return arch[id];
  endfunction

  function automatic logic [63:0] want_dbg(input int id);
    return (id >= NREGS) ? 64'd0 : arch[id];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every negative edge: all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("W_stat",     64'(W_stat),     64'(wi_stat));
      check("W_icode",    64'(W_icode),    64'(wi_icode));
      check("halted",     64'(halted),     64'(m_halted));
      check("retire_cnt", 64'(retire_cnt), 64'(m_retired[CNT_W-1:0]));
      check("valA",       valA,            want_read(int'(srcA)));
      check("valB",       valB,            want_read(int'(srcB)));
      check("dbg_data",   dbg_data,        want_dbg(int'(dbg_addr)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input logic [3:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  task automatic idle();
    set_m(4'h1, I_NOP, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; w_stall = 1'b0; w_bubble = 1'b0;
    idle();
    srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'h0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // Reset image and W bubble.
    dbg_addr = 4'd7; #1;
    check("reset dbg7", dbg_data, 64'd7);
    check("reset halted", 64'(halted), 64'd0);
    check("reset cnt", 64'(retire_cnt), 64'd0);
    check("reset W_icode", 64'(W_icode), 64'd1);

    // irmovq $0x55, %rdx: bypass after 1 edge, file after 2.
    set_m(4'h1, I_IRMOVQ, 64'h55, 64'd0, 4'd2, 4'hF);
    tick(); idle();
    srcA = 4'd2; dbg_addr = 4'd2; #1;
    check("irmovq bypass", valA, 64'h55);
    check("irmovq file early", dbg_data, 64'd2);
    tick(); #1;
    check("irmovq file", dbg_data, 64'h55);
    check("irmovq cnt", 64'(retire_cnt), 64'd1);

    // popq %rsp: M wins on dstE == dstM.
    set_m(4'h1, I_POPQ, 64'h108, 64'hAB, 4'd4, 4'd4);
    tick(); idle();
    srcA = 4'd4; #1;
    check("popq rsp bypass", valA, 64'hAB);
    tick();
    dbg_addr = 4'd4; #1;
    check("popq rsp file", dbg_data, 64'hAB);
    // popq %rbx: both ports write different registers on one edge.
    set_m(4'h1, I_POPQ, 64'h110, 64'h77, 4'd4, 4'd3);
    tick(); idle(); tick();
    dbg_addr = 4'd4; #1;
    check("popq rbx rsp", dbg_data, 64'h110);
    dbg_addr = 4'd3; #1;
    check("popq rbx rbx", dbg_data, 64'h77);
    check("popq cnt", 64'(retire_cnt), 64'd3);

    // ADR followed by a valid irmovq: nothing written, halt sticks.
    set_m(4'h3, I_MRMOVQ, 64'hFF, 64'd0, 4'd1, 4'hF);
    tick();
    set_m(4'h1, I_IRMOVQ, 64'h99, 64'd0, 4'd1, 4'hF);
    tick(); idle(); tick(); tick();
    dbg_addr = 4'd1; srcA = 4'd1; #1;
    check("adr halted", 64'(halted), 64'd1);
    check("adr reg1", dbg_data, 64'd1);
    check("adr no bypass", valA, 64'd1);
    check("adr cnt", 64'(retire_cnt), 64'd3);
    set_m(4'h1, I_IRMOVQ, 64'h42, 64'd0, 4'd5, 4'hF);
    tick(); tick();
    dbg_addr = 4'd5; #1;
    check("halt frozen cnt", 64'(retire_cnt), 64'd3);
    check("halt ignores input", dbg_data, 64'd5);
    rst = 1'b1; tick(); rst = 1'b0; idle(); #1;
    check("rst clears halted", 64'(halted), 64'd0);
    check("rst clears cnt", 64'(retire_cnt), 64'd0);

    // Stall+bubble together holds and re-commits; bubble alone inserts NOP.
    set_m(4'h1, I_IRMOVQ, 64'h500, 64'd0, 4'd5, 4'hF);
    tick();
    w_stall = 1'b1; w_bubble = 1'b1;
    set_m(4'h1, I_IRMOVQ, 64'h600, 64'd0, 4'd6, 4'hF);
    tick(); tick();
    dbg_addr = 4'd5; #1;
    check("hold W_icode", 64'(W_icode), 64'd3);
    check("hold reg5", dbg_data, 64'h500);
    check("hold cnt", 64'(retire_cnt), 64'd2);
    dbg_addr = 4'd6; #1;
    check("hold reg6", dbg_data, 64'd6);
    w_stall = 1'b0;
    tick(); tick(); #1;
    check("bubble W_icode", 64'(W_icode), 64'd1);
    check("bubble cnt", 64'(retire_cnt), 64'd3);
    check("bubble reg6", dbg_data, 64'd6);
    w_bubble = 1'b0; idle();

    // RNONE destination does not write; id 14 does; id 15 reads 0.
    set_m(4'h1, I_CMOVXX, 64'hAA, 64'd0, 4'hF, 4'hF);
    tick();
    set_m(4'h1, I_IRMOVQ, 64'hEE, 64'd0, 4'd14, 4'hF);
    tick(); idle(); tick(); tick();
    dbg_addr = 4'd14; #1;
    check("reg14 write", dbg_data, 64'hEE);
    dbg_addr = 4'd15; srcA = 4'd15; #1;
    check("dbg id15", dbg_data, 64'd0);
    check("valA id15", valA, 64'd0);
    check("rnone cnt", 64'(retire_cnt), 64'd5);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      w_stall  = ($urandom_range(0, 7) == 0);
      w_bubble = ($urandom_range(0, 7) == 0);
      m_stat   = ($urandom_range(0, 99) < 98) ? 4'h1 : 4'($urandom_range(0, 4));
      m_icode  = 4'($urandom_range(0, 11));
      m_valE   = {$urandom, $urandom};
      m_valM   = {$urandom, $urandom};
      m_dstE   = 4'($urandom_range(0, 15));
      m_dstM   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      srcA     = 4'($urandom_range(0, 15));
      srcB     = ($urandom_range(0, 1) == 0) ? m_dstE : 4'($urandom_range(0, 15));
      dbg_addr = 4'($urandom_range(0, 15));
      tick();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile_param.md
Name: wb_regfile_param

Overview:
- Parametrised successor to the pipeline write-back stage.
- Owns the W pipeline register (stall/bubble control) and an NREGS x DATA_W register file with independent E and M write ports.
- Provides two bypassed decode read ports and a debug read port, replacing the per-register output buses.
- Gates commits on pipeline status: sticky halt on any non-AOK stat, plus a retired-instruction counter.

Parameters:
- DATA_W, 64: register/data width.
- NREGS, 15: architectural register count (indices 0..NREGS-1).
- ADDR_W, 4: register-id width; all-ones value (RNONE, 0xF at default) means "no register".
- RESET_INIT, 1: 0 = reset all registers to 0; 1 = reset register i to value i.
- CNT_W, 32: retire counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- w_stall  in  1  hold W register contents.
- w_bubble  in  1  load NOP into W register.
- m_stat  in  4  stat from memory stage (AOK=1, HLT=2, ADR=3, INS=4).
- m_icode  in  4  icode from memory stage.
- m_valE  in  DATA_W  ALU result.
- m_valM  in  DATA_W  memory read data.
- m_dstE  in  ADDR_W  E destination (RNONE = none; cmov-not-taken already RNONE).
- m_dstM  in  ADDR_W  M destination.
- srcA, srcB  in  ADDR_W  decode read addresses.
- valA, valB  out  DATA_W  decode read data (bypassed).
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data (unbypassed file contents).
- W_stat  out  4  registered W-stage stat.
- W_icode  out  4  registered W-stage icode.
- halted  out  1  sticky halt flag.
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=1 at posedge; overrides all other inputs):
  - file per RESET_INIT.
  - W register = bubble: icode NOP(1), stat AOK, dstE=dstM=RNONE, valE=valM=0.
  - halted=0, retire_cnt=0.
  - A reset asserted mid-run discards the in-flight W write that cycle.
- W register update at posedge:
  - Load when !rst && !halted; hold otherwise.
  - Priority: w_stall > w_bubble > load M inputs. Stall and bubble together: hold.
- Commit at posedge, from current W_* contents (one cycle after W load):
  - Precondition: W_stat==AOK and !halted; otherwise no write.
  - E port: write W_valE to W_dstE if dstE != RNONE and dstE < NREGS.
  - M port: write W_valM to W_dstM under the same conditions.
  - dstE==dstM (popq %rsp): M wins; the file holds valM.
  - Writes are no longer decoded from icode. Upstream must supply dstE=4 for push/pop/call/ret.
- Halt:
  - At posedge with W_stat != AOK: halted<=1.
  - halted stays 1 until rst.
  - The offending instruction does not write and does not retire.
- retire_cnt: +1 at posedge when W_stat==AOK, !halted, W_icode != NOP. Wraps modulo 2^CNT_W.
- Read ports (combinational, same-cycle):
  - Pending committing write to the same id: M port first, then E port.
  - Otherwise file contents.
  - id == RNONE or id >= NREGS returns 0.
  - No bypass while halted or W_stat != AOK.
- dbg_data: file[dbg_addr], 0 if out of range. Never bypassed.
- W_stat, W_icode: direct register outputs.
- Latency: M input to file visible = 2 posedges; to valA/valB via bypass = 1 posedge.

Decomposition:
- Shared package:
  - Stat codes AOK/HLT/ADR/INS.
  - Icode constants (NOP, HALT, RRMOVQ/CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ).
  - RNONE, RSP=4.
  - Packed struct for the W-stage bundle {stat, icode, valE, valM, dstE, dstM}.
- One sub-module, regfile_2w3r: storage, M-over-E write priority, three read ports.
- Stage register, halt and counter logic stay in the top.

Test Plan:
- Reset, RESET_INIT=1 -> dbg_addr=7 reads 7. halted=0, retire_cnt=0, W_icode=1.
- irmovq (icode 3, dstE=2, valE=0x55) -> after cycle 1, srcA=2 gives 0x55 via bypass. After cycle 2, dbg_addr=2 reads 0x55. retire_cnt=1.
- popq %rsp (dstE=4, valE=0x108, dstM=4, valM=0xAB) -> reg4=0xAB. Also popq %rbx (dstM=3, valM=0x77): reg4=0x110, reg3=0x77 written the same edge.
- Stat=ADR with dstE=1, valE=0xFF, followed by a valid irmovq -> reg1 unchanged. halted=1. Later inputs are ignored and retire_cnt frozen. rst clears halted.
- w_stall and w_bubble asserted together with new M inputs -> W contents held and re-committed (same value). w_bubble alone -> W_icode=1, no write, no retire.
- dstE=0xF (cmov not taken), dstE=14 at NREGS=15, and dstE=15 at NREGS=15 -> RNONE and id 15 cause no write. id 14 writes. Reads of 15 return 0.
